// File: rtl/polyfinder_scheduler_if.sv
// Request, finder and result buses between the decode channels, the scheduler and the shared polynomial_finder.
// master = scheduler side, slave = channels/finder side.
interface polyfinder_scheduler_if #(
    parameter int NUM_CHANNELS = 4,
    parameter int CH_W         = 3
);
    logic [NUM_CHANNELS-1:0]    req_valid;
    logic [NUM_CHANNELS-1:0]    req_ack;
    logic [24*NUM_CHANNELS-1:0] req_ts_last_data;
    logic [24*NUM_CHANNELS-1:0] req_ts_last_data1;
    logic [17*NUM_CHANNELS-1:0] req_decoded_data;
    logic [17*NUM_CHANNELS-1:0] req_decoded_data1;

    logic        fin_enable;
    logic [23:0] fin_ts_last_data;
    logic [23:0] fin_ts_last_data1;
    logic [16:0] fin_decoded_data;
    logic [16:0] fin_decoded_data1;
    logic [16:0] fin_polynomial;
    logic [16:0] fin_iteration_number;
    logic        fin_ready;

    logic            res_valid;
    logic [CH_W-1:0] res_channel;
    logic [16:0]     res_polynomial;
    logic [16:0]     res_iteration;
    logic            res_found;
    logic            res_timeout;
    logic            busy;

    modport master (
        input  req_valid, req_ts_last_data, req_ts_last_data1, req_decoded_data, req_decoded_data1,
        input  fin_polynomial, fin_iteration_number, fin_ready,
        output req_ack, fin_enable, fin_ts_last_data, fin_ts_last_data1, fin_decoded_data, fin_decoded_data1,
        output res_valid, res_channel, res_polynomial, res_iteration, res_found, res_timeout, busy
    );

    modport slave (
        output req_valid, req_ts_last_data, req_ts_last_data1, req_decoded_data, req_decoded_data1,
        output fin_polynomial, fin_iteration_number, fin_ready,
        input  req_ack, fin_enable, fin_ts_last_data, fin_ts_last_data1, fin_decoded_data, fin_decoded_data1,
        input  res_valid, res_channel, res_polynomial, res_iteration, res_found, res_timeout, busy
    );
endinterface

// File: rtl/polyfinder_scheduler.sv
// Round-robin sharing of one polynomial_finder across NUM_CHANNELS decode channels.
// state | meaning: IDLE settle/grant, ISSUE raise enable, WAIT_BUSY finder ack, WAIT_DONE finder result, CAPTURE latch result
module polyfinder_scheduler #(
    parameter int NUM_CHANNELS   = 4,
    parameter int CH_W           = 3,
    parameter int TIMEOUT_CYCLES = 1048592,
    parameter int SETTLE_CYCLES  = 2
) (
    input  logic                   clk_72MHz,
    input  logic                   rst_n,
    polyfinder_scheduler_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_CAPTURE
    } state_t;

    localparam logic [20:0] TO_LAST   = 21'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  SETTLE_LD = 8'(SETTLE_CYCLES);

    state_t                  state_q, state_d;
    logic [20:0]             to_cnt_q, to_cnt_d;
    logic [7:0]              settle_q, settle_d;
    logic [CH_W-1:0]         ptr_q, ptr_d;
    logic [CH_W-1:0]         gnt_q, gnt_d;
    logic [23:0]             ts0_q, ts0_d, ts1_q, ts1_d;
    logic [16:0]             dd0_q, dd0_d, dd1_q, dd1_d;
    logic                    fin_en_q, fin_en_d;
    logic [NUM_CHANNELS-1:0] ack_q, ack_d;
    logic                    res_valid_q, res_valid_d;
    logic [CH_W-1:0]         res_ch_q, res_ch_d;
    logic [16:0]             res_poly_q, res_poly_d;
    logic [16:0]             res_iter_q, res_iter_d;
    logic                    res_found_q, res_found_d;
    logic                    res_to_q, res_to_d;

    logic                    hit;
    logic [CH_W-1:0]         pick;
    logic [CH_W:0]           cand;
    logic [NUM_CHANNELS-1:0] req_shift;

    always_comb begin
        hit       = 1'b0;
        pick      = '0;
        cand      = '0;
        req_shift = '0;
        // first pending channel at or after the pointer, wrapping at NUM_CHANNELS
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            cand = {1'b0, ptr_q} + (CH_W+1)'(k);
            if (cand >= (CH_W+1)'(NUM_CHANNELS)) begin
                cand = cand - (CH_W+1)'(NUM_CHANNELS);
            end
            req_shift = bus.req_valid >> cand;
            if (!hit && req_shift[0]) begin
                hit  = 1'b1;
                pick = cand[CH_W-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        to_cnt_d    = to_cnt_q;
        settle_d    = settle_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        ts0_d       = ts0_q;
        ts1_d       = ts1_q;
        dd0_d       = dd0_q;
        dd1_d       = dd1_q;
        fin_en_d    = fin_en_q;
        ack_d       = '0;
        res_valid_d = 1'b0;
        res_ch_d    = res_ch_q;
        res_poly_d  = res_poly_q;
        res_iter_d  = res_iter_q;
        res_found_d = res_found_q;
        res_to_d    = res_to_q;

        case (state_q)
            S_IDLE: begin
                fin_en_d = 1'b0;
                if (settle_q != 8'd0) begin
                    settle_d = settle_q - 8'd1;
                end else if (hit) begin
                    gnt_d   = pick;
                    ptr_d   = (pick == CH_W'(NUM_CHANNELS - 1)) ? '0 : pick + CH_W'(1);
                    ts0_d   = bus.req_ts_last_data[24*pick +: 24];
                    ts1_d   = bus.req_ts_last_data1[24*pick +: 24];
                    dd0_d   = bus.req_decoded_data[17*pick +: 17];
                    dd1_d   = bus.req_decoded_data1[17*pick +: 17];
                    ack_d   = NUM_CHANNELS'(1) << pick;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                fin_en_d = 1'b1;
                to_cnt_d = '0;
                state_d  = S_WAIT_BUSY;
            end
            S_WAIT_BUSY, S_WAIT_DONE: begin
                if (to_cnt_q == TO_LAST) begin
                    fin_en_d    = 1'b0;
                    res_valid_d = 1'b1;
                    res_ch_d    = gnt_q;
                    res_poly_d  = '0;
                    res_iter_d  = '0;
                    res_found_d = 1'b0;
                    res_to_d    = 1'b1;
                    settle_d    = SETTLE_LD;
                    state_d     = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 21'd1;
                    if (state_q == S_WAIT_BUSY && !bus.fin_ready) begin
                        state_d = S_WAIT_DONE;
                    end else if (state_q == S_WAIT_DONE && bus.fin_ready) begin
                        state_d = S_CAPTURE;
                    end
                end
            end
            S_CAPTURE: begin
                fin_en_d    = 1'b0;
                res_valid_d = 1'b1;
                res_ch_d    = gnt_q;
                res_poly_d  = bus.fin_polynomial;
                res_iter_d  = bus.fin_iteration_number;
                res_found_d = (bus.fin_polynomial != '0);
                res_to_d    = 1'b0;
                settle_d    = SETTLE_LD;
                state_d     = S_IDLE;
            end
            default: begin
                fin_en_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_72MHz) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            to_cnt_q    <= '0;
            settle_q    <= '0;
            ptr_q       <= '0;
            gnt_q       <= '0;
            ts0_q       <= '0;
            ts1_q       <= '0;
            dd0_q       <= '0;
            dd1_q       <= '0;
            fin_en_q    <= 1'b0;
            ack_q       <= '0;
            res_valid_q <= 1'b0;
            res_ch_q    <= '0;
            res_poly_q  <= '0;
            res_iter_q  <= '0;
            res_found_q <= 1'b0;
            res_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            to_cnt_q    <= to_cnt_d;
            settle_q    <= settle_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            ts0_q       <= ts0_d;
            ts1_q       <= ts1_d;
            dd0_q       <= dd0_d;
            dd1_q       <= dd1_d;
            fin_en_q    <= fin_en_d;
            ack_q       <= ack_d;
            res_valid_q <= res_valid_d;
            res_ch_q    <= res_ch_d;
            res_poly_q  <= res_poly_d;
            res_iter_q  <= res_iter_d;
            res_found_q <= res_found_d;
            res_to_q    <= res_to_d;
        end
    end

    assign bus.req_ack           = ack_q;
    assign bus.fin_enable        = fin_en_q;
    assign bus.fin_ts_last_data  = ts0_q;
    assign bus.fin_ts_last_data1 = ts1_q;
    assign bus.fin_decoded_data  = dd0_q;
    assign bus.fin_decoded_data1 = dd1_q;
    assign bus.res_valid         = res_valid_q;
    assign bus.res_channel       = res_ch_q;
    assign bus.res_polynomial    = res_poly_q;
    assign bus.res_iteration     = res_iter_q;
    assign bus.res_found         = res_found_q;
    assign bus.res_timeout       = res_to_q;
    assign bus.busy              = (state_q != S_IDLE);
endmodule

// File: tb/tb_polyfinder_scheduler.sv
// Bench for polyfinder_scheduler: behavioural finder and channel models, round-robin reference and
// timing expectations derived from the scheduling rules, directed scenarios then a randomized phase.
module tb_polyfinder_scheduler;
    localparam int N      = 4;
    localparam int CH_W   = 3;
    localparam int TO     = 100;
    localparam int SETTLE = 2;

    logic clk_72MHz = 1'b0;
    logic rst_n     = 1'b0;
    always #7 clk_72MHz = ~clk_72MHz;

    polyfinder_scheduler_if #(.NUM_CHANNELS(N), .CH_W(CH_W)) bus();

    polyfinder_scheduler #(
        .NUM_CHANNELS  (N),
        .CH_W          (CH_W),
        .TIMEOUT_CYCLES(TO),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk_72MHz(clk_72MHz),
        .rst_n    (rst_n),
        .bus      (bus.master)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [23:0] ts0[N], ts1[N];
    logic [16:0] dd0[N], dd1[N];

    int          last_g = -1;
    bit          job_active, job_started;
    int          job_ch;
    logic [23:0] ex_ts0, ex_ts1;
    logic [16:0] ex_d0, ex_d1, ex_poly, ex_iter;
    bit          ex_found, ex_to;
    int          ack_cyc, en_cyc, rdy_cyc;
    bit          gap_armed;
    int          gap_start;
    bit [N-1:0]  rearm, rearm_due, rearm_go;
    int          jobs_done = 0;
    int          grant_log[$];
    bit          rand_on = 0;

    bit          fm_busy;
    int          fm_cnt, fm_lat, fm_drop;
    bit          fm_hang;
    logic [16:0] fm_poly, fm_iter;
    bit          cfg_rand = 0;
    int          cfg_lat = 20, cfg_drop = 1;
    bit          cfg_hang = 0;
    logic [16:0] cfg_poly = 17'h1, cfg_iter = 17'h1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [N-1:0] pend);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k + N) % N;
            if (pend[c]) return c;
        end
        return -1;
    endfunction

    task automatic new_data(input int i);
        ts0[i] = 24'($urandom);
        ts1[i] = 24'($urandom);
        dd0[i] = 17'($urandom);
        dd1[i] = 17'($urandom);
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            bus.req_ts_last_data[24*i +: 24]  = ts0[i];
            bus.req_ts_last_data1[24*i +: 24] = ts1[i];
            bus.req_decoded_data[17*i +: 17]  = dd0[i];
            bus.req_decoded_data1[17*i +: 17] = dd1[i];
        end
    endtask

    task automatic request(input int i);
        new_data(i);
        drive_reqs();
        bus.req_valid[i] = 1'b1;
    endtask

    task automatic monitor();
        int g;
        g = -1;
        if (bus.req_ack != '0) begin
            for (int i = 0; i < N; i++) if (bus.req_ack[i]) g = i;
            check("ack_onehot", 64'($countones(bus.req_ack)), 1);
            check("ack_while_job", job_active, 0);
            check("grant_channel", g, rr_pick(last_g, bus.req_valid));
            check("fin_ts_at_grant", {bus.fin_ts_last_data, bus.fin_ts_last_data1}, {ts0[g], ts1[g]});
            check("fin_dec_at_grant", {bus.fin_decoded_data, bus.fin_decoded_data1}, {dd0[g], dd1[g]});
            if (gap_armed) check("settle_gap", cyc - gap_start, SETTLE + 1);
            gap_armed   = 0;
            last_g      = g;
            job_active  = 1;
            job_started = 0;
            job_ch      = g;
            ex_ts0 = ts0[g]; ex_ts1 = ts1[g]; ex_d0 = dd0[g]; ex_d1 = dd1[g];
            ack_cyc = cyc;
            grant_log.push_back(g);
            bus.req_valid[g] = 1'b0;
            new_data(g);
            if (rearm[g]) begin
                rearm[g]     = 0;
                rearm_due[g] = 1;
            end
        end
        if (bus.res_valid) begin
            check("res_expected", job_active & job_started, 1);
            if (job_active) begin
                check("res_channel", bus.res_channel, job_ch);
                check("res_polynomial", bus.res_polynomial, ex_poly);
                check("res_iteration", bus.res_iteration, ex_iter);
                check("res_found", bus.res_found, ex_found);
                check("res_timeout", bus.res_timeout, ex_to);
                check("fin_enable_at_res", bus.fin_enable, 0);
                check("fin_ts_stable", {bus.fin_ts_last_data, bus.fin_ts_last_data1}, {ex_ts0, ex_ts1});
                check("fin_dec_stable", {bus.fin_decoded_data, bus.fin_decoded_data1}, {ex_d0, ex_d1});
                if (ex_to) check("timeout_latency", cyc - en_cyc, TO);
                else       check("result_latency", cyc - rdy_cyc, 2);
                jobs_done++;
                job_active = 0;
            end
            if (bus.req_valid != '0) begin
                gap_armed = 1;
                gap_start = cyc;
            end
        end
    endtask

    task automatic finder_model();
        if (!fm_busy) begin
            if (bus.fin_enable) begin
                fm_busy = 1;
                fm_cnt  = 0;
                en_cyc  = cyc;
                if (cfg_rand) begin
                    fm_lat  = $urandom_range(3, 70);
                    fm_drop = $urandom_range(0, 1);
                    fm_hang = ($urandom_range(0, 7) == 0);
                    fm_poly = ($urandom_range(0, 3) == 0) ? 17'h0 : 17'($urandom);
                    fm_iter = 17'($urandom);
                end else begin
                    fm_lat = cfg_lat; fm_drop = cfg_drop; fm_hang = cfg_hang;
                    fm_poly = cfg_poly; fm_iter = cfg_iter;
                end
                if (job_active) begin
                    check("enable_latency", cyc - ack_cyc, 1);
                    job_started = 1;
                    ex_to    = fm_hang;
                    ex_poly  = fm_hang ? 17'h0 : fm_poly;
                    ex_iter  = fm_hang ? 17'h0 : fm_iter;
                    ex_found = !fm_hang && (fm_poly != 17'h0);
                end
                if (fm_drop == 0) bus.fin_ready = 1'b0;
            end else begin
                bus.fin_ready = 1'b1;
            end
        end else if (!bus.fin_enable) begin
            fm_busy       = 0;
            bus.fin_ready = 1'b1;
        end else begin
            fm_cnt++;
            if (fm_cnt == fm_drop) bus.fin_ready = 1'b0;
            if (fm_cnt == fm_lat && !fm_hang) begin
                bus.fin_ready            = 1'b1;
                bus.fin_polynomial       = fm_poly;
                bus.fin_iteration_number = fm_iter;
                rdy_cyc                  = cyc;
            end
        end
    endtask

    task automatic step();
        @(negedge clk_72MHz);
        cyc++;
        monitor();
        finder_model();
        for (int i = 0; i < N; i++) begin
            if (rearm_go[i]) bus.req_valid[i] = 1'b1;
        end
        rearm_go  = rearm_due;
        rearm_due = '0;
        if (rand_on && $urandom_range(0, 5) == 0) begin
            int c;
            c = $urandom_range(0, N - 1);
            if (!bus.req_valid[c]) begin
                new_data(c);
                bus.req_valid[c] = 1'b1;
            end
        end
        drive_reqs();
    endtask

    task automatic apply_reset(input int cycles);
        rst_n      = 1'b0;
        job_active = 0;
        last_g     = -1;
        gap_armed  = 0;
        repeat (cycles) step();
        rst_n = 1'b1;
    endtask

    task automatic drain(input string tag, input int budget);
        int k;
        bit done;
        k = 0;
        done = 0;
        while (k < budget && !done) begin
            step();
            k++;
            done = (bus.req_valid == '0) && (rearm_go == '0) && (rearm_due == '0) && !job_active && !bus.busy;
        end
        check(tag, done, 1);
    endtask

    task automatic set_cfg(input int lat, input int drop, input bit hang, input logic [16:0] poly,
                           input logic [16:0] iter);
        cfg_rand = 0; cfg_lat = lat; cfg_drop = drop; cfg_hang = hang; cfg_poly = poly; cfg_iter = iter;
    endtask

    initial begin
        int base;
        int k;
        bus.req_valid            = '0;
        bus.fin_ready            = 1'b1;
        bus.fin_polynomial       = '0;
        bus.fin_iteration_number = '0;
        for (int i = 0; i < N; i++) new_data(i);
        drive_reqs();

        apply_reset(3);
        check("rst_busy", bus.busy, 0);
        check("rst_fin_enable", bus.fin_enable, 0);
        check("rst_req_ack", bus.req_ack, 0);
        check("rst_res", {bus.res_valid, bus.res_found, bus.res_timeout, bus.res_channel}, 0);
        check("rst_res_data", {bus.res_polynomial, bus.res_iteration}, 0);
        check("rst_fin_ops", {bus.fin_ts_last_data, bus.fin_ts_last_data1, bus.fin_decoded_data}, 0);

        set_cfg(50, 1, 0, 17'h1d258, 17'd1234);
        base = jobs_done;
        request(2);
        drain("single_drain", 300);
        check("single_jobs", jobs_done - base, 1);

        apply_reset(2);
        set_cfg(20, 1, 0, 17'h0abcd, 17'd99);
        grant_log.delete();
        base = jobs_done;
        for (int i = 0; i < N; i++) request(i);
        drain("all4_drain", 600);
        check("all4_jobs", jobs_done - base, 4);
        check("all4_count", grant_log.size(), 4);
        foreach (grant_log[i]) check("all4_order", grant_log[i], i);

        set_cfg(15, 0, 0, 17'h0, 17'd777);
        request(1);
        drain("notfound_drain", 200);

        set_cfg(30, 1, 1, 17'h1, 17'h1);
        request(3);
        drain("timeout_drain", 400);

        set_cfg(60, 1, 0, 17'h155, 17'd42);
        request(1);
        k = 0;
        while (k < 60 && !(fm_busy && fm_cnt >= 10)) begin
            step();
            k++;
        end
        check("rst_mid_reached", fm_busy && fm_cnt >= 10, 1);
        rst_n      = 1'b0;
        job_active = 0;
        last_g     = -1;
        gap_armed  = 0;
        step();
        check("rst_mid_fin_enable", bus.fin_enable, 0);
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_res_valid", bus.res_valid, 0);
        request(1);
        request(3);
        step();
        step();
        rst_n = 1'b1;
        grant_log.delete();
        set_cfg(12, 1, 0, 17'h00f0f, 17'd5);
        drain("rst_mid_drain", 400);
        check("rst_mid_count", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            check("rst_mid_first", grant_log[0], 1);
            check("rst_mid_second", grant_log[1], 3);
        end

        set_cfg(10, 1, 0, 17'h00321, 17'd8);
        grant_log.delete();
        rearm[0] = 1;
        request(0);
        request(3);
        drain("reassert_drain", 400);
        check("reassert_count", grant_log.size(), 3);
        if (grant_log.size() == 3) begin
            check("reassert_first", grant_log[0], 0);
            check("reassert_second", grant_log[1], 3);
            check("reassert_third", grant_log[2], 0);
        end

        cfg_rand = 1;
        rand_on  = 1;
        base = jobs_done;
        k = 0;
        while (k < 8000 && jobs_done - base < 30) begin
            step();
            k++;
        end
        check("random_jobs_reached", jobs_done - base >= 30, 1);
        rand_on = 0;
        drain("random_drain", 1500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1400000;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog");
    end
endmodule
